dmem_responder: RTL and testbench

//  Responder end of the datapath's data-memory interface: accepts one load/store

---
 rtl/dmem_if_pkg.sv | 17 +
 rtl/dmem_word_array.sv | 26 ++
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_if_pkg.sv
// Shared definitions for the data-memory request/response interface.
// Used by the responder, the control unit's memory stage and the bench.
package dmem_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_OFS_W = 2;

    localparam logic ERR_OK     = 1'b0;
    localparam logic ERR_ACCESS = 1'b1;

endpackage

// File: rtl/dmem_word_array.sv
// Word storage behind the responder: synchronous write, asynchronous read.
// Contents are never cleared by reset.
module dmem_word_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, a fixed
// access latency, then a held response carrying read data and an error flag.
module dmem_responder
    import dmem_if_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH_WORDS * WORD_BYTES);

    dmem_state_e       state, next_state;
    logic [3:0]        cnt, next_cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              accept;
    logic              do_access;
    logic              addr_err;
    logic              mem_we;
    logic [IDX_W-1:0]  word_idx;
    logic [DATA_W-1:0] mem_rdata;

    assign accept    = (state == ST_IDLE) && req_valid && req_ready;
    assign do_access = (state == ST_WAIT) && (cnt == 4'd0);

    // Full-width compare so addresses above the array never alias onto low words.
    assign addr_err = (lat_addr[BYTE_OFS_W-1:0] != '0) || (lat_addr >= ADDR_LIMIT);
    assign word_idx = lat_addr[BYTE_OFS_W +: IDX_W];

    // Gating with rst_n keeps a store from committing on an edge that resets.
    assign mem_we = do_access && rst_n && lat_we && !addr_err;

    dmem_word_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .widx  (word_idx),
        .wdata (lat_wdata),
        .ridx  (word_idx),
        .rdata (mem_rdata)
    );

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_WAIT;
                    next_cnt   = 4'(LATENCY);
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = ST_RESP;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_valid && resp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= ERR_OK;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            req_ready <= (next_state == ST_IDLE);
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            // Response registers load once on entry to RESP and hold until taken.
            if (do_access) begin
                resp_valid <= 1'b1;
                resp_err   <= addr_err ? ERR_ACCESS : ERR_OK;
                resp_rdata <= (!lat_we && !addr_err) ? mem_rdata : '0;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
                resp_err   <= ERR_OK;
                resp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0 instance.
// Stimulus pushes expected responses; monitors pop and compare on each handshake.
module tb_dmem_responder;
    import dmem_if_pkg::*;

    localparam int LAT       = 2;
    localparam int DEPTH     = 64;
    localparam int ARR_BYTES = DEPTH * WORD_BYTES;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        req_valid_0, req_ready_0, req_we_0;
    logic [31:0] req_addr_0, req_wdata_0;
    logic        resp_valid_0, resp_ready_0, resp_err_0;
    logic [31:0] resp_rdata_0;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];
    exp_t sbq0[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_0), .req_ready(req_ready_0), .req_we(req_we_0),
        .req_addr(req_addr_0), .req_wdata(req_wdata_0),
        .resp_valid(resp_valid_0), .resp_ready(resp_ready_0),
        .resp_rdata(resp_rdata_0), .resp_err(resp_err_0)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Monitor for the LATENCY=2 instance; latency is measured from accept to first valid.
    exp_t m_e;
    int   m_vcyc = 0;
    bit   m_prev = 1'b0;
    always @(negedge clk) begin
        if (resp_valid && !m_prev) m_vcyc = cyc;
        m_prev = resp_valid;
        if (resp_valid && resp_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_resp actual=valid expected=none");
            end else begin
                m_e = sbq.pop_front();
                checkOutput("resp_rdata", resp_rdata, m_e.rdata);
                checkOutput("resp_err", 32'(resp_err), 32'(m_e.err));
                checkOutput("latency", 32'(m_vcyc - m_e.acc_cyc), 32'(LAT + 1));
            end
        end
    end

    exp_t m0_e;
    int   m0_vcyc = 0;
    bit   m0_prev = 1'b0;
    always @(negedge clk) begin
        if (resp_valid_0 && !m0_prev) m0_vcyc = cyc;
        m0_prev = resp_valid_0;
        if (resp_valid_0 && resp_ready_0) begin
            if (sbq0.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_resp0 actual=valid expected=none");
            end else begin
                m0_e = sbq0.pop_front();
                checkOutput("resp_rdata0", resp_rdata_0, m0_e.rdata);
                checkOutput("resp_err0", 32'(resp_err_0), 32'(m0_e.err));
                checkOutput("latency0", 32'(m0_vcyc - m0_e.acc_cyc), 32'd1);
            end
        end
    end

    task automatic applyStimulus(input bit use0, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                 input bit exp_err, input bit wait_resp);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!(use0 ? req_ready_0 : req_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("[TB] FAIL ready_timeout actual=0 expected=1");
            return;
        end
        if (use0) begin
            req_valid_0 = 1'b1; req_we_0 = we; req_addr_0 = addr; req_wdata_0 = wdata;
        end else begin
            req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        end
        @(posedge clk);
        #1;
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        e.acc_cyc = cyc;
        if (use0) begin
            sbq0.push_back(e);
            req_valid_0 = 1'b0;
        end else begin
            sbq.push_back(e);
            req_valid = 1'b0;
        end
        if (wait_resp) begin
            n = 0;
            while (((use0 ? sbq0.size() : sbq.size()) != 0) && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) begin
                checks++;
                failures++;
                $display("[TB] FAIL resp_timeout actual=none expected=response");
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        req_valid_0 = 1'b0; req_we_0 = 1'b0; req_addr_0 = '0; req_wdata_0 = '0; resp_ready_0 = 1'b1;

        // Reset held for three edges, then released.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Store then load back.
        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

        // Error cases: misaligned, past the end, far above (no wrap), erroneous stores.
        applyStimulus(0, 1'b1, 32'h0FC, 32'h0BADF00D, 32'h0, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, 32'h000, 32'h55AA55AA, 32'h0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 32'(ARR_BYTES), 32'h0, 32'h0, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 32'h102, 32'h1234, 32'h0, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 32'h100, 32'h9999, 32'h0, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 32'h0FC, 32'h0, 32'h0BADF00D, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 32'h000, 32'h0, 32'h55AA55AA, 1'b0, 1'b1);

        // Backpressure: response must hold while a new request is ignored.
        resp_ready = 1'b0;
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("[TB] FAIL bp_valid_timeout actual=0 expected=1");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h77777777;
            checkOutput("bp_resp_valid", 32'(resp_valid), 32'd1);
            checkOutput("bp_resp_rdata", resp_rdata, 32'hDEADBEEF);
            checkOutput("bp_resp_err", 32'(resp_err), 32'd0);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_valid", 32'(resp_valid), 32'd0);
        checkOutput("bp_release_rdata", resp_rdata, 32'd0);
        checkOutput("bp_release_ready", 32'(req_ready), 32'd1);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

        // Reset one cycle after accepting a store: nothing committed, no response.
        applyStimulus(0, 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("midrst_no_resp", 32'(resp_valid), 32'd0);
        applyStimulus(0, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 1'b1);

        // Zero-latency instance.
        applyStimulus(1, 1'b1, 32'h04, 32'hCAFE0004, 32'h0, 1'b0, 1'b1);
        applyStimulus(1, 1'b0, 32'h04, 32'h0, 32'hCAFE0004, 1'b0, 1'b1);
        applyStimulus(1, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1'b1);

        repeat (5) @(negedge clk);
        checkOutput("sbq_empty", 32'(sbq.size()), 32'd0);
        checkOutput("sbq0_empty", 32'(sbq0.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
